mem_stall_ctrl: RTL and testbench

Parametrised successor to the datapath's memory stall unit. It sits between the MEM stage and the data-cache port. It passes plain loads/stores through, and walks a configurable-depth pointer chain for indirect accesses (LDI/STI and deeper) while holding the pipeline. Pointers are captured only on a response, and the block waits for the instruction fetch so no access is ever re-issued.

---
 rtl/mem_stall_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_stall_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stall_ctrl.sv
// Memory stall controller between the MEM stage and the data-cache port: plain accesses pass
// through, indirect accesses walk a pointer chain while holding the pipeline.
// Optional stall counter output enabled by defining MEM_STALL_PERF_EN.
module mem_stall_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int OFF_W   = 4,
    parameter int DATA_W  = 16,
    parameter int MAX_IND = 2,
    parameter int LVL_W   = $clog2(MAX_IND + 1),
    parameter int CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    mem_read_in,
    input  logic                    mem_write_in,
    input  logic [ADDR_W-OFF_W-1:0] mem_address_in,
    input  logic [OFF_W-1:0]        line_offset_in,
    input  logic [LVL_W-1:0]        indirect_level,
    input  logic                    indirect_is_store,
    input  logic                    mem_resp,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    ifetch_resp,
    output logic                    stall_pipeline,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_W-OFF_W-1:0] mem_address,
    output logic [OFF_W-1:0]        line_offset_out,
    output logic                    busy
`ifdef MEM_STALL_PERF_EN
    ,
    output logic [CNT_W-1:0]        stall_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHAIN,
        S_FINAL,
        S_WAIT_IF
    } state_t;

    state_t           state, next_state;
    logic [ADDR_W-1:0] ptr, ptr_d;
    logic [LVL_W-1:0]  lvl_cnt, lvl_cnt_d;
    logic [LVL_W-1:0]  lvl_eff;
    logic              indirect;

    // Levels deeper than the hardware supports are clamped rather than rejected.
    always_comb begin
        lvl_eff = indirect_level;
        if (indirect_level > LVL_W'(MAX_IND)) begin
            lvl_eff = LVL_W'(MAX_IND);
        end
    end

    assign indirect = (lvl_eff != '0);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            ptr     <= '0;
            lvl_cnt <= '0;
        end else begin
            state   <= next_state;
            ptr     <= ptr_d;
            lvl_cnt <= lvl_cnt_d;
        end
    end

    always_comb begin
        next_state      = state;
        ptr_d           = ptr;
        lvl_cnt_d       = lvl_cnt;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = mem_address_in;
        line_offset_out = line_offset_in;
        stall_pipeline  = 1'b1;

        case (state)
            S_IDLE: begin
                mem_read       = indirect | mem_read_in;
                mem_write      = !indirect & mem_write_in;
                stall_pipeline = ((mem_read_in | mem_write_in | indirect) & !mem_resp)
                                 | !ifetch_resp | indirect;
                if (indirect && mem_resp) begin
                    ptr_d      = mem_rdata[ADDR_W-1:0];
                    lvl_cnt_d  = lvl_eff - LVL_W'(1);
                    next_state = (lvl_eff > LVL_W'(1)) ? S_CHAIN : S_FINAL;
                end else if (!indirect && (mem_read_in || mem_write_in)
                             && mem_resp && !ifetch_resp) begin
                    next_state = S_WAIT_IF;
                end
            end
            S_CHAIN: begin
                mem_read        = 1'b1;
                mem_address     = ptr[ADDR_W-1:OFF_W];
                line_offset_out = ptr[OFF_W-1:0];
                if (mem_resp) begin
                    ptr_d     = mem_rdata[ADDR_W-1:0];
                    lvl_cnt_d = lvl_cnt - LVL_W'(1);
                    if (lvl_cnt == LVL_W'(1)) begin
                        next_state = S_FINAL;
                    end
                end
            end
            S_FINAL: begin
                mem_address     = ptr[ADDR_W-1:OFF_W];
                line_offset_out = ptr[OFF_W-1:0];
                mem_write       = indirect_is_store;
                mem_read        = !indirect_is_store;
                stall_pipeline  = !mem_resp | !ifetch_resp;
                if (mem_resp) begin
                    next_state = ifetch_resp ? S_IDLE : S_WAIT_IF;
                end
            end
            S_WAIT_IF: begin
                stall_pipeline = !ifetch_resp;
                if (ifetch_resp) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase

        // While reset is held no cache access may escape and the pipeline stays frozen.
        if (!reset_n) begin
            mem_read       = 1'b0;
            mem_write      = 1'b0;
            stall_pipeline = 1'b1;
        end
    end

`ifdef MEM_STALL_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (stall_pipeline && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Randomised bench for mem_stall_ctrl: each operation is expanded into its expected list of
// cache transactions, and the DUT is checked cycle by cycle against that list.
module tb_mem_stall_ctrl;

    localparam int ADDR_W  = 16;
    localparam int OFF_W   = 4;
    localparam int DATA_W  = 16;
    localparam int MAX_IND = 2;
    localparam int LVL_W   = 2;
    localparam int CNT_W   = 32;
    localparam int LA_W    = ADDR_W - OFF_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              mem_read_in, mem_write_in;
    logic [LA_W-1:0]   mem_address_in;
    logic [OFF_W-1:0]  line_offset_in;
    logic [LVL_W-1:0]  indirect_level;
    logic              indirect_is_store;
    logic              mem_resp;
    logic [DATA_W-1:0] mem_rdata;
    logic              ifetch_resp;
    logic              stall_pipeline, mem_read, mem_write, busy;
    logic [LA_W-1:0]   mem_address;
    logic [OFF_W-1:0]  line_offset_out;
`ifdef MEM_STALL_PERF_EN
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  exp_count;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic            rd;
        logic            wr;
        logic [LA_W-1:0] addr;
        logic [OFF_W-1:0] off;
    } txn_t;

    txn_t txn_q[$];

    always #5 clk = ~clk;

    mem_stall_ctrl #(
        .ADDR_W(ADDR_W), .OFF_W(OFF_W), .DATA_W(DATA_W),
        .MAX_IND(MAX_IND), .LVL_W(LVL_W), .CNT_W(CNT_W)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .mem_read_in      (mem_read_in),
        .mem_write_in     (mem_write_in),
        .mem_address_in   (mem_address_in),
        .line_offset_in   (line_offset_in),
        .indirect_level   (indirect_level),
        .indirect_is_store(indirect_is_store),
        .mem_resp         (mem_resp),
        .mem_rdata        (mem_rdata),
        .ifetch_resp      (ifetch_resp),
        .stall_pipeline   (stall_pipeline),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_address      (mem_address),
        .line_offset_out  (line_offset_out),
        .busy             (busy)
`ifdef MEM_STALL_PERF_EN
        ,
        .stall_count      (stall_count)
`endif
    );

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_perf(input logic exp_stall);
`ifdef MEM_STALL_PERF_EN
        check_output("stall_count", stall_count, exp_count);
        if (exp_stall && exp_count != '1) exp_count = exp_count + 1;
`else
        if (exp_stall) begin end
`endif
    endtask

    // Cycles with no memory op in the MEM stage; stray responses must be ignored.
    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            mem_read_in    = 1'b0;
            mem_write_in   = 1'b0;
            indirect_level = '0;
            mem_address_in = LA_W'($urandom);
            line_offset_in = OFF_W'($urandom);
            mem_resp       = 1'($urandom);
            mem_rdata      = DATA_W'($urandom);
            ifetch_resp    = 1'($urandom);
            @(negedge clk);
            check_output("idle_rd", mem_read, 0);
            check_output("idle_wr", mem_write, 0);
            check_output("idle_stall", stall_pipeline, !ifetch_resp);
            check_output("idle_busy", busy, 0);
            check_output("idle_addr", {line_offset_out, mem_address}, {line_offset_in, mem_address_in});
            check_perf(!ifetch_resp);
            @(posedge clk);
            #1;
        end
    endtask

    // Present one op and act as the cache; fixed_lat < 0 picks random latencies.
    task automatic apply_stimulus(input logic [LA_W-1:0] a, input logic [OFF_W-1:0] o,
                                  input int lvl, input logic st, input logic rd, input logic wr,
                                  input logic [15:0] p0, input logic [15:0] p1,
                                  input int fixed_lat, input int if_delay);
        logic [15:0] pv [2];
        int eff, n, idx, lat, ifc;
        bit finished;
        logic exp_stall;
        txn_t t;
        pv[0] = p0;
        pv[1] = p1;
        eff = (lvl > MAX_IND) ? MAX_IND : lvl;
        txn_q.delete();
        if (eff == 0) begin
            t = '{rd, wr, a, o};
            txn_q.push_back(t);
        end else begin
            t = '{1'b1, 1'b0, a, o};
            txn_q.push_back(t);
            for (int i = 0; i < eff; i++) begin
                if (i == eff - 1) t = '{!st, st, pv[i][15:4], pv[i][3:0]};
                else              t = '{1'b1, 1'b0, pv[i][15:4], pv[i][3:0]};
                txn_q.push_back(t);
            end
        end
        n = txn_q.size();
        idx = 0;
        lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        ifc = if_delay;
        finished = 0;
        mem_read_in       = rd;
        mem_write_in      = wr;
        mem_address_in    = a;
        line_offset_in    = o;
        indirect_level    = LVL_W'(lvl);
        indirect_is_store = st;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            mem_resp    = (idx < n) && (lat == 0);
            ifetch_resp = (ifc == 0);
            mem_rdata   = (idx < eff) ? pv[idx] : DATA_W'($urandom);
            @(negedge clk);
            if (idx < n) begin
                exp_stall = !((idx == n - 1) && mem_resp && ifetch_resp);
                check_output("rd", mem_read, txn_q[idx].rd);
                check_output("wr", mem_write, txn_q[idx].wr);
                check_output("addr", mem_address, txn_q[idx].addr);
                check_output("off", line_offset_out, txn_q[idx].off);
            end else begin
                exp_stall = !ifetch_resp;
                check_output("wait_rd", mem_read, 0);
                check_output("wait_wr", mem_write, 0);
            end
            check_output("stall", stall_pipeline, exp_stall);
            check_output("busy", busy, idx > 0);
            check_perf(exp_stall);
            @(posedge clk);
            #1;
            if (idx < n && mem_resp) begin
                idx++;
                lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            end else if (idx < n && lat > 0) begin
                lat--;
            end
            if (idx == n && ifetch_resp) finished = 1;
            if (ifc > 0) ifc--;
        end
        if (!finished) check_output("op_timeout", 0, 1);
        mem_resp = 1'b0;
    endtask

    task automatic reset_mid_chain();
        apply_reset_inputs:
        begin
            mem_read_in       = 1'b0;
            mem_write_in      = 1'b0;
            mem_address_in    = 12'h0AB;
            line_offset_in    = 4'h3;
            indirect_level    = 2'd2;
            indirect_is_store = 1'b1;
            mem_resp          = 1'b1;
            mem_rdata         = 16'h5676;
            ifetch_resp       = 1'b1;
        end
        @(posedge clk);
        #1;
        mem_resp = 1'b0;
        #1;
        check_output("chain_rd", mem_read, 1);
        check_output("chain_addr", mem_address, 12'h567);
        reset_n = 1'b0;
        #1;
        check_output("rst_rd", mem_read, 0);
        check_output("rst_wr", mem_write, 0);
        check_output("rst_stall", stall_pipeline, 1);
        check_output("rst_busy", busy, 0);
        check_output("rst_addr", mem_address, 12'h0AB);
`ifdef MEM_STALL_PERF_EN
        exp_count = '0;
`endif
        indirect_level = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(12'h0AB, 4'h3, 2, 1'b1, 1'b0, 1'b0, 16'h5676, 16'h9ABC, 1, 0);
    endtask

    initial begin
        reset_n           = 1'b0;
        mem_read_in       = 1'b1;
        mem_write_in      = 1'b1;
        mem_address_in    = 12'h321;
        line_offset_in    = 4'h9;
        indirect_level    = '0;
        indirect_is_store = 1'b0;
        mem_resp          = 1'b0;
        mem_rdata         = '0;
        ifetch_resp       = 1'b1;
`ifdef MEM_STALL_PERF_EN
        exp_count = '0;
`endif
        #12;
        check_output("reset_rd", mem_read, 0);
        check_output("reset_wr", mem_write, 0);
        check_output("reset_stall", stall_pipeline, 1);
        check_output("reset_busy", busy, 0);
        check_output("reset_addr", {line_offset_out, mem_address}, {4'h9, 12'h321});
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        apply_stimulus(12'h123, 4'h4, 0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 3, 0);
        idle_cycles(1);
        apply_stimulus(12'h040, 4'h0, 1, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h0, 0, 0);
        idle_cycles(1);
        apply_stimulus(12'h001, 4'h0, 2, 1'b1, 1'b0, 1'b0, 16'h2000, 16'h3004, 1, 0);
        idle_cycles(1);
        apply_stimulus(12'h055, 4'h1, 1, 1'b0, 1'b0, 1'b0, 16'h7712, 16'h0, 0, 5);
        apply_stimulus(12'h066, 4'h2, 0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 0, 3);
        apply_stimulus(12'h0F0, 4'hE, 3, 1'b1, 1'b0, 1'b0, 16'hA5A5, 16'h1234, 0, 0);
        reset_mid_chain();

        for (int k = 0; k < 150; k++) begin
            logic rd_sel;
            rd_sel = 1'($urandom);
            idle_cycles(int'($urandom_range(0, 2)));
            apply_stimulus(LA_W'($urandom), OFF_W'($urandom), int'($urandom_range(0, 3)),
                           1'($urandom), rd_sel, !rd_sel, 16'($urandom), 16'($urandom), -1,
                           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);
        end
        idle_cycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
